// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-back entry type
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG = 0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular FIFO with ordered dual push (push0 before push1) and single pop
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0_i,
  input  logic [W-1:0]  din0_i,
  input  logic          push1_i,
  input  logic [W-1:0]  din1_i,
  input  logic          pop_i,
  output logic [W-1:0]  mem_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PW-1:0] head_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d = head_q + PW'(pop_i);
    tail_d = tail_q + PW'(push0_i) + PW'(push1_i);
    count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    off = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      valid_o[i] = CW'(off) < count_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (push0_i || push1_i) mem_q[tail_q] <= push0_i ? din0_i : din1_i;
      if (push0_i && push1_i) mem_q[tail_q + PW'(1)] <= din1_i;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign mem_o = mem_q;
  assign head_o = head_q;
  assign count_o = count_q;
endmodule

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: queues ALU/load write-backs ahead of the regfile write port and flags read hazards
// Optional REGFILE_WB_FORWARD_EN adds FwdData1/FwdData2 carrying the youngest matching queued data.
module regfile_write_buffer import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AluValid,
  input  logic [ADDR_WIDTH-1:0] AluReg,
  input  logic [DATA_WIDTH-1:0] AluData,
  output logic                  AluReady,
  input  logic                  MemValid,
  input  logic [ADDR_WIDTH-1:0] MemReg,
  input  logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic                  Pending1,
  output logic                  Pending2,
  output logic [CW-1:0]         Count
`ifdef REGFILE_WB_FORWARD_EN
  ,
  output logic [DATA_WIDTH-1:0] FwdData1,
  output logic [DATA_WIDTH-1:0] FwdData2
`endif
);
  localparam int W = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_REG);
  logic [W-1:0] ents [DEPTH];
  logic [W-1:0] head;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] cnt, free;
  logic nonempty, push_mem, push_alu;
  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(Clk), .rst(Reset),
    .push0_i(push_mem), .din0_i({MemReg, MemData}),
    .push1_i(push_alu), .din1_i({AluReg, AluData}),
    .pop_i(nonempty),
    .mem_o(ents), .valid_o(valid), .head_o(head_ptr), .count_o(cnt)
  );
  // The head pops every cycle, so its slot is already free for this cycle's pushes
  always_comb begin
    head = ents[head_ptr];
    nonempty = cnt != '0;
    free = CW'(DEPTH) - cnt + CW'(nonempty);
    MemReady = !Reset && free != '0;
    AluReady = !Reset && (free >= CW'(2) || (free != '0 && !MemValid));
    push_mem = MemValid && MemReady && MemReg != ZERO_A;
    push_alu = AluValid && AluReady && AluReg != ZERO_A;
    RegWrite = !Reset && nonempty;
    WriteRegister = RegWrite ? head[W-1 -: ADDR_WIDTH] : '0;
    WriteData = RegWrite ? head[DATA_WIDTH-1:0] : '0;
    Count = Reset ? '0 : cnt;
    Pending1 = 1'b0;
    Pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && !Reset && ents[i][W-1 -: ADDR_WIDTH] == ReadRegister1 && ReadRegister1 != ZERO_A) Pending1 = 1'b1;
      if (valid[i] && !Reset && ents[i][W-1 -: ADDR_WIDTH] == ReadRegister2 && ReadRegister2 != ZERO_A) Pending2 = 1'b1;
    end
  end
`ifdef REGFILE_WB_FORWARD_EN
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the last match wins
  always_comb begin
    FwdData1 = '0;
    FwdData2 = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (!Reset && CW'(k) < cnt && ents[idx][W-1 -: ADDR_WIDTH] == ReadRegister1 && ReadRegister1 != ZERO_A) FwdData1 = ents[idx][DATA_WIDTH-1:0];
      if (!Reset && CW'(k) < cnt && ents[idx][W-1 -: ADDR_WIDTH] == ReadRegister2 && ReadRegister2 != ZERO_A) FwdData2 = ents[idx][DATA_WIDTH-1:0];
    end
  end
`endif
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: directed stimulus with a write-port scoreboard
module tb_regfile_write_buffer;
  import regfile_pkg::*;
  logic Clk, Reset, AluValid, AluReady, MemValid, MemReady, RegWrite, Pending1, Pending2;
  logic [4:0] AluReg, MemReg, WriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0] AluData, MemData, WriteData;
  logic [2:0] Count;
`ifdef REGFILE_WB_FORWARD_EN
  logic [31:0] FwdData1, FwdData2;
`endif
  wb_entry_t exp_q [$];
  int n_cmp = 0, n_fail = 0;

  regfile_write_buffer dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Pending1(Pending1), .Pending2(Pending2), .Count(Count)
`ifdef REGFILE_WB_FORWARD_EN
    , .FwdData1(FwdData1), .FwdData2(FwdData2)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    MemValid = mv; MemReg = mr; MemData = md;
    AluValid = av; AluReg = ar; AluData = ad;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
    wb_entry_t e;
    e.rd = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every regfile write must match the oldest expected entry
  always @(negedge Clk) begin
    if (RegWrite === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_write: got reg %0d data %0h, want no write", WriteRegister, WriteData);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        if (WriteRegister !== e.rd || WriteData !== e.data) begin
          n_fail++;
          $display("FAIL wb_write: got reg %0d data %0h, want reg %0d data %0h",
                   WriteRegister, WriteData, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    idle();
    Reset = 1'b1;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #2;
    chk("rst_count", 32'(Count), 0);
    chk("rst_aluready", 32'(AluReady), 0);
    chk("rst_memready", 32'(MemReady), 0);
    chk("rst_regwrite", 32'(RegWrite), 0);
    cyc();
    cyc();
    Reset = 1'b0;
    #1;
    chk("post_rst_count", 32'(Count), 0);
    chk("post_rst_memready", 32'(MemReady), 1);
    chk("post_rst_aluready", 32'(AluReady), 1);
    chk("post_rst_regwrite", 32'(RegWrite), 0);

    // single ALU write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd42);
    #1;
    chk("single_aluready", 32'(AluReady), 1);
    push_exp(5'd2, 32'd42);
    cyc();
    idle();
    #1;
    chk("single_count1", 32'(Count), 1);
    chk("single_regwrite", 32'(RegWrite), 1);
    cyc();
    chk("single_count0", 32'(Count), 0);

    // dual push, Mem before ALU
    drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB);
    #1;
    chk("dual_memready", 32'(MemReady), 1);
    chk("dual_aluready", 32'(AluReady), 1);
    push_exp(5'd5, 32'hAA);
    push_exp(5'd6, 32'hBB);
    cyc();
    idle();
    #1;
    chk("dual_count2", 32'(Count), 2);
    cyc();
    chk("dual_count1", 32'(Count), 1);
    cyc();
    chk("dual_count0", 32'(Count), 0);

    // fill to DEPTH
    drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80);
    push_exp(5'd7, 32'h70); push_exp(5'd8, 32'h80);
    cyc();
    drive(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0);
    push_exp(5'd9, 32'h90); push_exp(5'd10, 32'hA0);
    cyc();
    drive(1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0);
    #1;
    chk("fill_count3", 32'(Count), 3);
    push_exp(5'd11, 32'hB0); push_exp(5'd12, 32'hC0);
    cyc();
    drive(1'b1, 5'd13, 32'hD0, 1'b1, 5'd14, 32'hE0);
    #1;
    chk("full_count", 32'(Count), 4);
    chk("full_memready", 32'(MemReady), 1);
    chk("full_aluready", 32'(AluReady), 0);
    push_exp(5'd13, 32'hD0);
    cyc();
    idle();
    #1;
    chk("full_push_pop_count", 32'(Count), 4);
    repeat (4) cyc();
    chk("fill_drained", 32'(Count), 0);

    // zero register
    ReadRegister1 = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd15);
    #1;
    chk("zero_aluready", 32'(AluReady), 1);
    chk("zero_pending1", 32'(Pending1), 0);
    cyc();
    idle();
    #1;
    chk("zero_count", 32'(Count), 0);
    chk("zero_regwrite", 32'(RegWrite), 0);

    // hazard on duplicate destination
    ReadRegister1 = 5'd20;
    ReadRegister2 = 5'd5;
    drive(1'b1, 5'd20, 32'd15, 1'b1, 5'd20, 32'd32);
    #1;
    chk("haz_offer_pending1", 32'(Pending1), 0);
    push_exp(5'd20, 32'd15);
    push_exp(5'd20, 32'd32);
    cyc();
    idle();
    #1;
    chk("haz_count2", 32'(Count), 2);
    chk("haz_pending1_a", 32'(Pending1), 1);
    chk("haz_pending2", 32'(Pending2), 0);
`ifdef REGFILE_WB_FORWARD_EN
    chk("haz_fwd1_a", FwdData1, 32'd32);
`endif
    cyc();
    chk("haz_pending1_b", 32'(Pending1), 1);
`ifdef REGFILE_WB_FORWARD_EN
    chk("haz_fwd1_b", FwdData1, 32'd32);
`endif
    cyc();
    chk("haz_pending1_c", 32'(Pending1), 0);
`ifdef REGFILE_WB_FORWARD_EN
    chk("haz_fwd1_c", FwdData1, 32'd0);
`endif

    // reset mid-operation
    ReadRegister1 = 5'd4;
    ReadRegister2 = 5'd0;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    push_exp(5'd1, 32'h11); push_exp(5'd3, 32'h33);
    cyc();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
    push_exp(5'd4, 32'h44); push_exp(5'd5, 32'h55);
    cyc();
    idle();
    #1;
    chk("mid_count3", 32'(Count), 3);
    chk("mid_pending1", 32'(Pending1), 1);
    Reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_count", 32'(Count), 0);
    chk("mid_rst_regwrite", 32'(RegWrite), 0);
    chk("mid_rst_aluready", 32'(AluReady), 0);
    chk("mid_rst_memready", 32'(MemReady), 0);
    chk("mid_rst_pending1", 32'(Pending1), 0);
    cyc();
    Reset = 1'b0;
    #1;
    chk("after_rst_count", 32'(Count), 0);
    chk("after_rst_regwrite", 32'(RegWrite), 0);
    repeat (3) cyc();
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Write-back buffer directly upstream of the 32x32 register file write port.
- Accepts write-back requests from two producers, the ALU and the memory/load path, queues them in order and drains one per cycle into WriteRegister/WriteData/RegWrite.
- Reports per-read-port hazards so the operand-read stage can stall while a write to the register it reads is still queued.

Parameters:
- DEPTH, 4, number of queued entries (power of two, >=2)
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- AluValid  in  1  ALU write-back request
- AluReg  in  ADDR_WIDTH  ALU destination register
- AluData  in  DATA_WIDTH  ALU result
- AluReady  out  1  ALU request accepted this cycle
- MemValid  in  1  load write-back request
- MemReg  in  ADDR_WIDTH  load destination register
- MemData  in  DATA_WIDTH  load data
- MemReady  out  1  load request accepted this cycle
- WriteRegister  out  ADDR_WIDTH  to regfile write address
- WriteData  out  DATA_WIDTH  to regfile write data
- RegWrite  out  1  to regfile write enable
- ReadRegister1  in  ADDR_WIDTH  snooped read-port-1 address
- ReadRegister2  in  ADDR_WIDTH  snooped read-port-2 address
- Pending1  out  1  queued write targets ReadRegister1
- Pending2  out  1  queued write targets ReadRegister2
- Count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage is a circular FIFO with head/tail pointers and Count. Pointers wrap modulo DEPTH.
- Drain:
  - When Count>0, the head entry drives WriteRegister/WriteData combinationally with RegWrite=1.
  - The regfile never back-pressures, so the head pops at every posedge while Count>0.
  - When Count==0: RegWrite=0, WriteRegister=0, WriteData=0.
- Free slots this cycle: free = DEPTH - Count + (Count>0).
- Acceptance (combinational ready; transfer happens when valid&&ready at posedge):
  - MemReady = free>=1.
  - AluReady = free>=2 || (free>=1 && !MemValid).
  - Memory has priority because loads are older.
  - When both are accepted in the same cycle, Mem is enqueued first, then ALU.
- Register 0:
  - A request with Reg==0 is accepted (ready as above) but is not enqueued. It does not consume a slot, so free counts only non-zero requests.
  - Register 0 is never Pending.
- Latency:
  - A request accepted at edge N is presented at the regfile port during cycle N+1 if the queue was empty, and committed at edge N+1.
  - Otherwise it is presented after all older entries.
- Pending1/Pending2: combinational OR over valid entries of (entry.reg==ReadRegisterX && ReadRegisterX!=0). Requests being offered this cycle are not included.
- Duplicate destinations: all are enqueued in order. Pending stays high until the last matching entry has drained.
- Full: simultaneous pop and push at Count==DEPTH is legal because free includes the pop. Count never exceeds DEPTH.
- Reset:
  - Reset=1 at a posedge clears Count and both pointers.
  - During Reset=1: AluReady=0, MemReady=0, RegWrite=0, Pending1=0, Pending2=0, WriteRegister=0, WriteData=0, Count=0.
  - A reset mid-operation discards all queued entries; none reach the regfile.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- When defined:
  - Adds outputs FwdData1 and FwdData2 (DATA_WIDTH), each carrying the data of the youngest queued entry matching its read address.
  - When Pending is 0, FwdDataX=0.
  - Pending then indicates that forwarded data is valid, not that a stall is needed.
- When undefined: the FwdData ports and the youngest-match logic are absent, and Pending is a stall request only.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=0
  - wb_entry_t (reg, data)
- One sub-module, wb_fifo: generic DEPTH-entry FIFO with dual push (ordered) and single pop, exposing its entry array and valid mask for the hazard compare.

Test Plan:
- Single write, ALU reg 2 data 42 at edge 0, Mem idle -> cycle 1: RegWrite=1, WriteRegister=2, WriteData=42; Count=0 after edge 1.
- Dual push, Mem(reg 5, 0xAA) and ALU(reg 6, 0xBB) in the same cycle on an empty queue -> both ready; drain order is reg 5 then reg 6 on consecutive cycles.
- Fill, DEPTH=4, hold the drain target busy by pushing 2/cycle for 3 cycles -> Count saturates at 4. With MemValid=1 at Count==4, MemReady=1 (free=1) and AluReady=0.
- Zero register, ALU reg 0 data 15 -> AluReady=1, Count unchanged, RegWrite stays 0; Pending1=0 with ReadRegister1=0.
- Hazard, enqueue reg 20 twice (15, then 32) with ReadRegister1=20 -> Pending1=1 for two cycles, then 0. With REGFILE_WB_FORWARD_EN, FwdData1=32 while both entries are queued.
- Reset mid-operation, Count=3, Reset=1 for one edge -> Count=0, RegWrite=0, all ready/Pending outputs=0; no further regfile writes.
